// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: single-cycle registered fetch with halt/fault detection
// and a program-load write port that stays live in every state, including reset.
module instr_fetch_mem #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 32,
  parameter int                 ADDR_W    = 32,
  parameter logic [DATA_W-1:0]  HALT_WORD = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req,
  input  logic [ADDR_W-1:0]          pc,
  output logic [DATA_W-1:0]          instr,
  output logic                       valid,
  output logic                       halted,
  output logic [1:0]                 fault,
  output logic [CNT_W-1:0]           fetch_count,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [DATA_W-1:0]          load_data
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Memory powers up full of HALT_WORD so a stray fetch of unloaded space stops cleanly.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: HALT_WORD};

  state_t             state_q;
  logic [DATA_W-1:0]  instr_q;
  logic               valid_q;
  logic               halted_q;
  logic [1:0]         fault_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               misaligned;
  logic               out_of_range;
  logic [DATA_W-1:0]  rd_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = ((pc >> 2) >= ADDR_W'(DEPTH));
  assign rd_word      = mem_q[pc[AW+1:2]];

  // Write port ignores reset; the read above sees the pre-edge contents (read-before-write).
  always_ff @(posedge clock) begin
    if (load_en && ({1'b0, load_addr} < (AW+1)'(DEPTH)))
      mem_q[load_addr] <= load_data;
  end

  // Fetch stage: decode the request and register the response one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RUN;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == S_RUN && req) begin
        if (misaligned) begin
          state_q <= S_FAULT;
          fault_q <= 2'b01;
        end else if (out_of_range) begin
          state_q <= S_FAULT;
          fault_q <= 2'b10;
        end else if (rd_word == HALT_WORD) begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end else begin
          instr_q <= rd_word;
          valid_q <= 1'b1;
          cnt_q   <= sat_inc(cnt_q);
        end
      end
    end
  end

  assign instr       = instr_q;
  assign valid       = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: two instances (16-bit and 2-bit fetch counters)
// share one stimulus stream and are checked against a behavioural model.
module tb_instr_fetch_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] pc;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;

  logic [31:0] instr_a, instr_b;
  logic        valid_a, valid_b, halted_a, halted_b;
  logic [1:0]  fault_a, fault_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clock = ~clock;

  instr_fetch_mem #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .HALT_WORD(32'h0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .req(req), .pc(pc),
    .instr(instr_a), .valid(valid_a), .halted(halted_a), .fault(fault_a), .fetch_count(cnt_a),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instr_fetch_mem #(.DATA_W(32), .DEPTH(32), .ADDR_W(32), .HALT_WORD(32'h0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .req(req), .pc(pc),
    .instr(instr_b), .valid(valid_b), .halted(halted_b), .fault(fault_b), .fetch_count(cnt_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct {
    int          stepn;
    logic        valid;
    logic [31:0] instr;
    logic        halted;
    logic [1:0]  fault;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int stepn  = 0;

  // Behavioural model: memory array plus the architectural status, counts kept unbounded.
  logic [31:0] m_mem [32];
  logic        m_halt;
  logic [1:0]  m_fault;
  logic [31:0] m_instr;
  int          m_cnt;

  task automatic check(input string name, input int sn, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, sn, act, expv);
    end
  endtask

  task automatic model_edge(input bit r, input bit rq, input logic [31:0] p,
                            input bit le, input logic [4:0] la, input logic [31:0] ld,
                            output logic v);
    v = 1'b0;
    if (r) begin
      m_halt = 1'b0; m_fault = 2'b00; m_cnt = 0; m_instr = '0;
    end else if (!m_halt && m_fault == 2'b00 && rq) begin
      if (p % 4 != 0)              m_fault = 2'b01;
      else if (p / 4 >= 32)        m_fault = 2'b10;
      else if (m_mem[p / 4] == 0)  m_halt = 1'b1;
      else begin
        m_instr = m_mem[p / 4];
        v = 1'b1;
        m_cnt++;
      end
    end
    if (le) m_mem[la] = ld;
  endtask

  task automatic step(input bit r, input bit rq, input logic [31:0] p,
                      input bit le, input logic [4:0] la, input logic [31:0] ld);
    exp_t e;
    logic v;
    reset = r; req = rq; pc = p; load_en = le; load_addr = la; load_data = ld;
    @(posedge clock);
    model_edge(r, rq, p, le, la, ld, v);
    stepn++;
    e.stepn  = stepn;
    e.valid  = v;
    e.instr  = m_instr;
    e.halted = m_halt;
    e.fault  = m_fault;
    e.cnt    = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt2   = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic fetch(input logic [31:0] p);
    step(1'b0, 1'b1, p, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Monitor: compares both instances against the record pushed for this edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valid_a",  e.stepn, 32'(valid_a),  32'(e.valid));
      check("valid_b",  e.stepn, 32'(valid_b),  32'(e.valid));
      check("instr_a",  e.stepn, instr_a,       e.instr);
      check("instr_b",  e.stepn, instr_b,       e.instr);
      check("halted_a", e.stepn, 32'(halted_a), 32'(e.halted));
      check("fault_a",  e.stepn, 32'(fault_a),  32'(e.fault));
      check("fault_b",  e.stepn, 32'(fault_b),  32'(e.fault));
      check("count_a",  e.stepn, 32'(cnt_a),    32'(e.cnt));
      check("count_b",  e.stepn, 32'(cnt_b),    32'(e.cnt2));
    end
  end

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h00100133; prog[1] = 32'h000A2183; prog[2] = 32'h01518233; prog[3] = 32'h0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_halt = 1'b0; m_fault = 2'b00; m_instr = '0; m_cnt = 0;

    // Program loaded while reset is held, then a request during reset that must be dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 5'(i), prog[i]);
    step(1'b1, 1'b1, 32'h0, 1'b0, 5'd0, 32'h0);

    fetch(32'd0); fetch(32'd4); fetch(32'd8);
    step(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'h0);
    fetch(32'd12); fetch(32'd0); fetch(32'd4);

    do_reset();
    fetch(32'd6); fetch(32'd0);
    do_reset(); fetch(32'd0);

    fetch(32'd128); fetch(32'd4);
    do_reset(); fetch(32'd130);
    do_reset();

    // Same-edge load and fetch of word 1 returns the old word, then the new one.
    step(1'b0, 1'b1, 32'd4, 1'b1, 5'd1, 32'hDEADBEEF);
    fetch(32'd4);

    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'd0);
    step(1'b1, 1'b1, 32'd4, 1'b0, 5'd0, 32'h0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'h0);

    // Randomised phase: fill a random program, then mixed fetches, loads and resets.
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 32'h0, 1'b1, 5'(i), ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom);
    for (int n = 0; n < 400; n++) begin
      bit          r, rq, le;
      logic [31:0] p;
      int          sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      p = ($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) p = 32'($urandom_range(32, 200)) << 2;
      else               p = 32'($urandom_range(0, 31)) << 2;
      r  = ((m_halt || m_fault != 2'b00) && $urandom_range(0, 2) == 0) || ($urandom_range(0, 40) == 0);
      rq = ($urandom_range(0, 3) != 0);
      le = ($urandom_range(0, 4) == 0);
      step(r, rq, p, le, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
    end

    @(negedge clock); @(negedge clock);
    check("queue_drained", stepn, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
